// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: counting-pattern words, optional packetisation, fixed or LFSR-random inter-word gaps.
// Latency: first beat valid one cycle after an accepted start; done pulses one cycle after the final handshake.
// Backpressure: holds tdata/tvalid/tlast stable while tready is low; optional stall counter via TRAFFIC_GEN_STALL_STATS_EN.
module axis_traffic_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [1:0]            gap_mode,
  input  logic [7:0]            gap_fixed,
  input  logic [15:0]           seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_sent,
  output logic [31:0]           stall_count
);

  localparam int LANES = DATA_WIDTH / 32;
  // Gap counter must hold both the 8-bit fixed gap and the random gap field.
  localparam int GW = (GAP_LOG2 > 8) ? GAP_LOG2 : 8;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [GW-1:0]        GAP_ONE = GW'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  pcnt_q, pcnt_d;
  logic [LEN_WIDTH-1:0]  nw_q, nw_d;
  logic [LEN_WIDTH-1:0]  pl_q, pl_d;
  logic [1:0]            mode_q, mode_d;
  logic [7:0]            gfix_q, gfix_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;

  logic                  hs;
  logic [LEN_WIDTH-1:0]  idx_nx;
  logic [LEN_WIDTH-1:0]  pcnt_nx;
  logic [GW-1:0]         gap_sel;

  // Lane k of word i carries i + k (mod 2^32).
  function automatic logic [DATA_WIDTH-1:0] word_data(input logic [LEN_WIDTH-1:0] i);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      d[32*k +: 32] = 32'(i) + 32'(k);
    end
    return d;
  endfunction

  // pcnt tracks i mod pkt_len incrementally so no divider is needed.
  function automatic logic last_for(input logic [LEN_WIDTH-1:0] i,
                                    input logic [LEN_WIDTH-1:0] pcnt,
                                    input logic [LEN_WIDTH-1:0] nw,
                                    input logic [LEN_WIDTH-1:0] pl);
    return ((pl != '0) && (pcnt == pl - LEN_ONE)) || (i == nw - LEN_ONE);
  endfunction

  // 16-bit Galois LFSR, right shift, taps 16'hB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Handshake, next word index/packet position and the gap for the current handshake.
  // The random gap uses the LFSR value present at the handshake, before it advances.
  always_comb begin
    hs      = tvalid_q & m_axis_tready;
    idx_nx  = idx_q + LEN_ONE;
    pcnt_nx = ((pl_q != '0) && (pcnt_q == pl_q - LEN_ONE)) ? '0 : pcnt_q + LEN_ONE;
    gap_sel = '0;
    case (mode_q)
      2'd1:    gap_sel = GW'(gfix_q);
      2'd2:    gap_sel = GW'(lfsr_q[GAP_LOG2-1:0]);
      default: gap_sel = '0;
    endcase
  end

  // Next-state and registered-output logic for IDLE / SEND / GAP.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pcnt_d    = pcnt_q;
    nw_d      = nw_q;
    pl_d      = pl_q;
    mode_d    = mode_q;
    gfix_d    = gfix_q;
    lfsr_d    = lfsr_q;
    gap_cnt_d = gap_cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    done_d    = 1'b0;
    words_d   = words_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            nw_d     = num_words;
            pl_d     = pkt_len;
            mode_d   = gap_mode;
            gfix_d   = gap_fixed;
            lfsr_d   = (seed == 16'h0000) ? 16'h0001 : seed;
            idx_d    = '0;
            pcnt_d   = '0;
            words_d  = '0;
            tdata_d  = word_data('0);
            tvalid_d = 1'b1;
            tlast_d  = last_for('0, '0, num_words, pkt_len);
            state_d  = SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (hs) begin
          if (words_q != '1) begin
            words_d = words_q + LEN_ONE;
          end
          if (idx_q == nw_q - LEN_ONE) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            if (mode_q == 2'd2) begin
              lfsr_d = lfsr_step(lfsr_q);
            end
            idx_d   = idx_nx;
            pcnt_d  = pcnt_nx;
            tdata_d = word_data(idx_nx);
            tlast_d = last_for(idx_nx, pcnt_nx, nw_q, pl_q);
            if (gap_sel != '0) begin
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_sel;
              state_d   = GAP;
            end
          end
        end
      end

      GAP: begin
        // Next word is already loaded; reassert valid after exactly gap_sel idle cycles.
        if (gap_cnt_q == GAP_ONE) begin
          tvalid_d = 1'b1;
          state_d  = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset also drops any same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pcnt_q    <= '0;
      nw_q      <= '0;
      pl_q      <= '0;
      mode_q    <= '0;
      gfix_q    <= '0;
      lfsr_q    <= 16'h0001;
      gap_cnt_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done_q    <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pcnt_q    <= pcnt_d;
      nw_q      <= nw_d;
      pl_q      <= pl_d;
      mode_q    <= mode_d;
      gfix_q    <= gfix_d;
      lfsr_q    <= lfsr_d;
      gap_cnt_q <= gap_cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      done_q    <= done_d;
      words_q   <= words_d;
    end
  end

`ifdef TRAFFIC_GEN_STALL_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Count saturating stall cycles; cleared when a non-empty run is accepted.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start && (num_words != '0)) begin
      stall_d = '0;
    end else if (tvalid_q && !m_axis_tready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign words_sent    = words_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: beat timing, data pattern, tlast, gaps, stalls, reset and start handling.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived constants plus a small LFSR reference for the random-gap run.
module tb_axis_traffic_gen;
  localparam int DW = 128;
  localparam int LW = 16;
  localparam int GL = 4;
`ifdef TRAFFIC_GEN_STALL_STATS_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] num_words;
  logic [LW-1:0] pkt_len;
  logic [1:0]    gap_mode;
  logic [7:0]    gap_fixed;
  logic [15:0]   seed;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_sent;
  logic [31:0]   stall_count;

  int compared   = 0;
  int mismatched = 0;

  int          nb;
  int          done_cnt;
  int          done_at;
  int          beat_cyc  [64];
  logic [31:0] beat_l0   [64];
  logic [31:0] beat_l3   [64];
  logic        beat_last [64];
  int          exp_cyc   [16];

  always #5 clk = ~clk;

  axis_traffic_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_LOG2(GL)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_words     (num_words),
    .pkt_len       (pkt_len),
    .gap_mode      (gap_mode),
    .gap_fixed     (gap_fixed),
    .seed          (seed),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .words_sent    (words_sent),
    .stall_count   (stall_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the falling edge where the first beat should be valid.
  task automatic do_start(input int nw, input int pl, input int mode, input int gf, input int sd);
    start     = 1'b1;
    num_words = LW'(nw);
    pkt_len   = LW'(pl);
    gap_mode  = 2'(mode);
    gap_fixed = 8'(gf);
    seed      = 16'(sd);
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_tvalid", 128'(m_axis_tvalid), 128'd1);
  endtask

  // Record handshakes and done pulses for a fixed number of cycles; optionally pulse start at cycle pulse_at.
  task automatic capture(input int budget, input int pulse_at);
    nb       = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < budget; c++) begin
      if (m_axis_tvalid && m_axis_tready && nb < 64) begin
        beat_cyc[nb]  = c;
        beat_l0[nb]   = m_axis_tdata[31:0];
        beat_l3[nb]   = m_axis_tdata[127:96];
        beat_last[nb] = m_axis_tlast;
        nb++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == pulse_at) begin
        start     = 1'b1;
        num_words = LW'(1);
        pkt_len   = LW'(1);
        gap_mode  = 2'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] lf;
    int          ec;
    logic [127:0] exp_w0;

    rst           = 1'b1;
    start         = 1'b0;
    num_words     = '0;
    pkt_len       = '0;
    gap_mode      = 2'd0;
    gap_fixed     = 8'd0;
    seed          = 16'd0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_tlast",  128'(m_axis_tlast),  128'd0);
    chk("rst_tdata",  m_axis_tdata,        128'd0);
    chk("rst_busy",   128'(busy),          128'd0);
    chk("rst_done",   128'(done),          128'd0);
    chk("rst_words",  128'(words_sent),    128'd0);
    chk("rst_stall",  128'(stall_count),   128'd0);
    rst = 1'b0;
    @(negedge clk);

    // 4 words, no packets, no gaps, always ready
    do_start(4, 0, 0, 0, 0);
    capture(8, -1);
    chk("t1_nbeats", 128'(nb), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_cycle", 128'(beat_cyc[i]),  128'(i));
      chk("t1_lane0", 128'(beat_l0[i]),   128'(i));
      chk("t1_lane3", 128'(beat_l3[i]),   128'(i + 3));
      chk("t1_tlast", 128'(beat_last[i]), 128'(i == 3));
    end
    chk("t1_done_at",  128'(done_at),    128'd4);
    chk("t1_done_cnt", 128'(done_cnt),   128'd1);
    chk("t1_busy_end", 128'(busy),       128'd0);
    chk("t1_words",    128'(words_sent), 128'd4);

    // 6 words, packets of 2, fixed gap 3: beats every 4 cycles
    do_start(6, 2, 1, 3, 0);
    capture(26, -1);
    chk("t2_nbeats", 128'(nb), 128'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_cycle", 128'(beat_cyc[i]),  128'(4 * i));
      chk("t2_lane0", 128'(beat_l0[i]),   128'(i));
      chk("t2_tlast", 128'(beat_last[i]), 128'(i % 2 == 1));
    end
    chk("t2_done_at", 128'(done_at),    128'd21);
    chk("t2_words",   128'(words_sent), 128'd6);

    // tready low for 5 cycles on the first beat
    m_axis_tready = 1'b0;
    do_start(3, 0, 0, 0, 0);
    exp_w0 = {32'd3, 32'd2, 32'd1, 32'd0};
    for (int s = 0; s < 5; s++) begin
      chk("t3_hold_tvalid", 128'(m_axis_tvalid), 128'd1);
      chk("t3_hold_tdata",  m_axis_tdata,        exp_w0);
      chk("t3_hold_tlast",  128'(m_axis_tlast),  128'd0);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    capture(6, -1);
    chk("t3_nbeats", 128'(nb), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_lane0", 128'(beat_l0[i]),   128'(i));
      chk("t3_cycle", 128'(beat_cyc[i]),  128'(i));
      chk("t3_tlast", 128'(beat_last[i]), 128'(i == 2));
    end
    chk("t3_stall", 128'(stall_count), 128'(STALL_EXP));
    chk("t3_words", 128'(words_sent),  128'd3);

    // Random gaps with seed 0 (acts as 16'h0001); reference LFSR predicts beat cycles
    lf = 16'h0001;
    ec = 0;
    for (int i = 0; i < 16; i++) begin
      exp_cyc[i] = ec;
      if (i < 15) begin
        ec = ec + 1 + int'(lf[GL-1:0]);
        lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
      end
    end
    do_start(16, 0, 2, 0, 0);
    capture(90, -1);
    chk("t4_nbeats", 128'(nb), 128'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t4_cycle", 128'(beat_cyc[i]), 128'(exp_cyc[i]));
      chk("t4_lane0", 128'(beat_l0[i]),  128'(i));
    end
    chk("t4_done_at", 128'(done_at), 128'(exp_cyc[15] + 1));

    // Start with zero words: done pulse only
    start     = 1'b1;
    num_words = '0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_done",   128'(done),          128'd1);
    chk("t5_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("t5_busy",   128'(busy),          128'd0);
    @(negedge clk);
    chk("t5_done_clear", 128'(done),          128'd0);
    chk("t5_tvalid2",    128'(m_axis_tvalid), 128'd0);

    // Start coincident with reset is dropped
    rst       = 1'b1;
    start     = 1'b1;
    num_words = LW'(5);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("t6_rststart_busy",   128'(busy),          128'd0);
    chk("t6_rststart_tvalid", 128'(m_axis_tvalid), 128'd0);
    @(negedge clk);
    chk("t6_rststart_busy2",  128'(busy),          128'd0);

    // Reset in the middle of a 10-word run
    do_start(10, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t6_midrun_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("t6_rst_busy",   128'(busy),          128'd0);
    chk("t6_rst_done",   128'(done),          128'd0);
    chk("t6_rst_words",  128'(words_sent),    128'd0);
    chk("t6_rst_tdata",  m_axis_tdata,        128'd0);
    rst = 1'b0;
    capture(6, -1);
    chk("t6_post_beats", 128'(nb),       128'd0);
    chk("t6_post_done",  128'(done_cnt), 128'd0);

    // Start pulsed while busy is ignored: 4 words, fixed gap 2
    do_start(4, 0, 1, 2, 0);
    capture(14, 1);
    chk("t7_nbeats", 128'(nb), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t7_cycle", 128'(beat_cyc[i]),  128'(3 * i));
      chk("t7_lane0", 128'(beat_l0[i]),   128'(i));
      chk("t7_tlast", 128'(beat_last[i]), 128'(i == 3));
    end
    chk("t7_done_at",  128'(done_at),    128'd10);
    chk("t7_done_cnt", 128'(done_cnt),   128'd1);
    chk("t7_words",    128'(words_sent), 128'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, giving the stream data width; it SHALL be a multiple of 32.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, giving the width of the word-count and packet-length fields.
REQ-003 The block SHALL have parameter GAP_LOG2, default 4, giving the width of the random gap field.
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a run; it is sampled only in IDLE.
REQ-007 num_words  in  LEN_WIDTH  number of words in the run.
REQ-008 pkt_len  in  LEN_WIDTH  words per packet; 0 means the only packet boundary is the final word.
REQ-009 gap_mode  in  2  0 = no gaps, 1 = fixed gap, 2 = LFSR-random gap, 3 = reserved (treated as 0).
REQ-010 gap_fixed  in  8  idle cycles inserted between words in mode 1.
REQ-011 seed  in  16  LFSR seed; a value of 0 is replaced by 16'h0001.
REQ-012 m_axis_tdata/m_axis_tvalid/m_axis_tlast  out  DATA_WIDTH/1/1  AXI-Stream master.
REQ-013 m_axis_tready  in  1  AXI-Stream ready.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when a run ends.
REQ-016 words_sent  out  LEN_WIDTH  number of handshakes completed in the current or most recent run.
REQ-017 stall_count  out  32  number of cycles with tvalid high and tready low (see Configuration).

Function
REQ-018 The state machine SHALL have three states, IDLE, SEND and GAP; outputs SHALL be registered.
REQ-019 In IDLE, start with num_words != 0 SHALL latch num_words, pkt_len, gap_mode, gap_fixed and seed, clear the word index, words_sent and stall_count, and enter SEND so that tvalid is high on the next cycle (one-cycle latency).
REQ-020 In IDLE, start with num_words == 0 SHALL remain in IDLE, emit no beat, and pulse done on the next cycle.
REQ-021 For word index i, 32-bit lane k of tdata (bits 32k+31:32k) SHALL equal i + k modulo 2^32.
REQ-022 In SEND, tdata, tvalid and tlast SHALL stay stable until tready is high (no retraction).
REQ-023 tlast SHALL be high when (pkt_len != 0 and i mod pkt_len == pkt_len-1) or i == num_words-1.
REQ-024 On a handshake of word num_words-1, the block SHALL enter IDLE, drop tvalid and pulse done on the following cycle.
REQ-025 On any other handshake, the gap g SHALL be 0 in mode 0, gap_fixed in mode 1, and the LFSR low GAP_LOG2 bits in mode 2; the LFSR advances once per handshake in mode 2 only.
REQ-026 If g == 0, the block SHALL present word i+1 with tvalid high on the next cycle (back-to-back throughput).
REQ-027 If g > 0, the block SHALL enter GAP with tvalid low for exactly g cycles, then return to SEND with word i+1.
REQ-028 The LFSR SHALL be a 16-bit Galois LFSR with taps 16'hB400, shifting right.
REQ-029 words_sent SHALL increment on every handshake and saturate at all-ones.
REQ-030 start SHALL be ignored while busy is high.

Reset
REQ-031 While rst is high, the block SHALL enter IDLE on that edge and set tvalid=0, tlast=0, tdata=0, done=0, busy=0, words_sent=0 and stall_count=0; reset mid-run SHALL abort the run without pulsing done.
REQ-032 A start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-033 With TRAFFIC_GEN_STALL_STATS_EN defined, stall_count SHALL increment, saturating at 32'hFFFFFFFF, on each cycle with tvalid=1 and tready=0, and SHALL clear on an accepted start.
REQ-034 Without TRAFFIC_GEN_STALL_STATS_EN, stall_count SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-035 Stimulus: num_words=4, pkt_len=0, mode 0, tready=1. Required response: 4 consecutive beats, lane0 = 0,1,2,3, lane3 = 3,4,5,6, tlast only on beat 4, done 1 cycle after beat 4.
REQ-036 Stimulus: num_words=6, pkt_len=2, mode 1, gap_fixed=3. Required response: tlast on beats 2, 4 and 6, exactly 3 tvalid-low cycles between beats, words_sent=6.
REQ-037 Stimulus: tready held low 5 cycles on beat 1, with the stats macro defined. Required response: tdata/tvalid stable throughout, stall_count=5, no beat lost.
REQ-038 Stimulus: mode 2, seed=0. Required response: gaps match a reference model seeded with 16'h0001.
REQ-039 Stimulus: start with num_words=0, then rst asserted mid-run of 10 words. Required response: done pulse with no beat; after reset tvalid=0 next cycle, busy=0, and no done pulse.
REQ-040 Stimulus: start pulsed while busy. Required response: ignored, and the run completes unchanged.
